systolic_array_is_driver: RTL and testbench
===========================================

// Module: systolic_array_is_driver
// PURPOSE
//  Sequencer and stream adapter that drives systolic_array_is from two
//  valid/ready source streams and delivers its results to a valid/ready sink.
//  Per job: load ARRAY_WIDTH stationary input vectors, stream N weight vectors,
//  then drain the pipeline. Emits exactly N psum vectors, in weight order.
//  Sits between the tile buffers and the array; it owns process_en/input_en.
// PARAMETERS
//  INPUT_WIDTH   16  input element width
//  WEIGHT_WIDTH  16  weight element width
//  PSUM_WIDTH    16  psum element width
//  ARRAY_HEIGHT  16  rows; input vector length
//  ARRAY_WIDTH   16  columns; weight/psum vector length
//  PIPE_LAT      ARRAY_HEIGHT+ARRAY_WIDTH  process_en-cycles from weight_in to its psum_out
//  CNT_WIDTH     16  width of vector-count field
// PORTS
//  clk         in   1                         clock
//  rst_n       in   1                         async active-low reset
//  start       in   1                         job start pulse; honoured only in IDLE
//  num_vecs    in   CNT_WIDTH                 weight vectors in job (N); sampled on start
//  in_valid    in   1                         input stream valid
//  in_ready    out  1                         input stream ready
//  in_data     in   INPUT_WIDTH x ARRAY_HEIGHT   input vector
//  w_valid     in   1                         weight stream valid
//  w_ready     out  1                         weight stream ready
//  w_data      in   WEIGHT_WIDTH x ARRAY_WIDTH   weight vector
//  process_en  out  1                         to array
//  input_en    out  1                         to array
//  input_in    out  INPUT_WIDTH x ARRAY_HEIGHT   to array
//  weight_in   out  WEIGHT_WIDTH x ARRAY_WIDTH   to array
//  psum_out    in   PSUM_WIDTH x ARRAY_WIDTH     from array
//  out_valid   out  1                         result valid
//  out_ready   in   1                         result ready
//  out_data    out  PSUM_WIDTH x ARRAY_WIDTH     result (= psum_out)
//  busy        out  1                         high when state != IDLE
//  done        out  1                         one-cycle pulse at end of job
// BEHAVIOUR
//  Reset: state=IDLE; all counters, tag pipe = 0; every output = 0.
//  FSM: IDLE -start & num_vecs!=0-> LOAD; start & num_vecs==0 -> done pulse, stay IDLE.
//   LOAD: input_en=in_valid; process_en=in_valid; in_ready=1; input_in=in_data.
//    Each handshake increments load_cnt; after ARRAY_WIDTH handshakes -> STREAM.
//    The first-loaded vector ends in the last column; the last-loaded in column 0.
//   STREAM: input_en=0; weight_in=w_data; w_ready=~stall; process_en=w_valid&~stall.
//    Each weight handshake pushes tag=1, increments sent_cnt; at sent_cnt==N -> DRAIN.
//   DRAIN: weight_in=0; process_en=~stall; tag=0 pushed; when tag pipe empty
//    and the last result has handshaked -> IDLE, done=1 for that cycle.
//  Tag pipe: PIPE_LAT-deep shift register; it advances only on process_en=1.
//   out_valid = tail tag; out_data = psum_out (combinational pass-through).
//  stall = out_valid & ~out_ready. While stalled, process_en=0, which freezes the array.
//   psum_out and out_data therefore hold stable until out_ready is high.
//  Weights are never accepted while stalled. A gap in w_valid inserts a frozen cycle,
//   not a bubble: the tags stay aligned with the psums.
//  in_ready=0 and w_ready=0 outside their states.
//   start during LOAD/STREAM/DRAIN is ignored.
//  Async reset mid-job aborts the job: FSM, counters and tags clear. No done is
//   emitted and undelivered results are discarded.
//  Counters are CNT_WIDTH wide. N = 2^CNT_WIDTH-1 completes without wrap.
// CONFIGURATION
//  IS_DRIVER_PERF_CNT_EN defined: adds ports stall_cycles and bubble_cycles (out, 32).
//   stall_cycles counts cycles with busy & stall.
//   bubble_cycles counts STREAM cycles with ~w_valid & ~stall.
//   Both counters clear on an accepted start and saturate at 2^32-1.
//  IS_DRIVER_PERF_CNT_EN undefined: the ports and counters are absent; all other
//   behaviour is identical.
// TESTING
//  T1 4x4, N=3, streams always valid, out_ready=1 -> out_valid after LOAD(4)+PIPE_LAT(8).
//     3 results match the golden matmul; done pulses once; busy falls the next cycle.
//  T2 As T1; drop out_ready for 5 cycles at the 2nd result -> process_en=0 for those 5.
//     out_data stays constant; results are unchanged and in order.
//  T3 w_valid low every other cycle, N=6 -> exactly 6 results, golden-equal, in order.
//     No extra out_valid beats.
//  T4 start with num_vecs=0 -> done next cycle; no in_ready/w_ready/process_en activity.
//  T5 rst_n low mid-STREAM (sent_cnt=2 of 5) -> all outputs 0 asynchronously.
//     A new job afterwards completes correctly.
//  T6 With IS_DRIVER_PERF_CNT_EN: rerun T2 -> stall_cycles=5, bubble_cycles=0.
//     Rerun T3 -> bubble_cycles=5.

Source files
------------

// File: rtl/systolic_array_is_driver.sv
// systolic_array_is_driver: loads stationary inputs, streams weights and drains systolic_array_is into a valid/ready sink.
// Define IS_DRIVER_PERF_CNT_EN to add the stall_cycles/bubble_cycles performance counters.
module systolic_array_is_driver #(
  parameter int INPUT_WIDTH  = 16,
  parameter int WEIGHT_WIDTH = 16,
  parameter int PSUM_WIDTH   = 16,
  parameter int ARRAY_HEIGHT = 16,
  parameter int ARRAY_WIDTH  = 16,
  parameter int PIPE_LAT     = ARRAY_HEIGHT + ARRAY_WIDTH,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [CNT_WIDTH-1:0]                 num_vecs,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [ARRAY_HEIGHT*INPUT_WIDTH-1:0]  in_data,
  input  logic                                 w_valid,
  output logic                                 w_ready,
  input  logic [ARRAY_WIDTH*WEIGHT_WIDTH-1:0]  w_data,
  output logic                                 process_en,
  output logic                                 input_en,
  output logic [ARRAY_HEIGHT*INPUT_WIDTH-1:0]  input_in,
  output logic [ARRAY_WIDTH*WEIGHT_WIDTH-1:0]  weight_in,
  input  logic [ARRAY_WIDTH*PSUM_WIDTH-1:0]    psum_out,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [ARRAY_WIDTH*PSUM_WIDTH-1:0]    out_data,
  output logic                                 busy,
  output logic                                 done
`ifdef IS_DRIVER_PERF_CNT_EN
  ,
  output logic [31:0]                          stall_cycles,
  output logic [31:0]                          bubble_cycles
`endif
);
  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;
  localparam int LW = $clog2(ARRAY_WIDTH + 1);
  localparam logic [LW-1:0] LAST_LOAD = LW'(ARRAY_WIDTH - 1);
  state_t state, state_nx;
  logic done_nx;
  logic [CNT_WIDTH-1:0] n_q, sent_cnt;
  logic [LW-1:0] load_cnt;
  logic [PIPE_LAT-1:0] tags;
  logic stall, in_hs, w_hs, start_ok;
  assign out_valid = tags[PIPE_LAT-1];
  assign stall = out_valid & ~out_ready;
  assign out_data = psum_out;
  assign busy = state != IDLE;
  assign in_hs = in_valid & in_ready;
  assign w_hs = w_valid & w_ready;
  assign start_ok = state == IDLE & start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      done <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    done_nx = 1'b0;
    case (state)
      IDLE: begin
        state_nx = start && num_vecs != '0 ? LOAD : IDLE;
        done_nx = start && num_vecs == '0;
      end
      LOAD: state_nx = in_hs && load_cnt == LAST_LOAD ? STREAM : LOAD;
      STREAM: state_nx = w_hs && sent_cnt == n_q - 1'b1 ? DRAIN : STREAM;
      DRAIN: begin
        state_nx = tags == '0 ? IDLE : DRAIN;
        done_nx = tags == '0;
      end
      default: state_nx = IDLE;
    endcase
  end

  // A stall freezes the array, so psum_out (and out_data) hold until accepted
  always_comb begin
    in_ready = state == LOAD;
    input_en = in_ready & in_valid;
    w_ready = state == STREAM & ~stall;
    process_en = state == LOAD ? in_valid :
                 state == STREAM ? w_valid & ~stall :
                 state == DRAIN & ~stall;
    input_in = in_ready ? in_data : '0;
    weight_in = state == STREAM ? w_data : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q <= '0;
      sent_cnt <= '0;
      load_cnt <= '0;
      tags <= '0;
    end else begin
      if (start_ok) begin
        n_q <= num_vecs;
        sent_cnt <= '0;
        load_cnt <= '0;
      end else begin
        if (in_hs) load_cnt <= load_cnt + 1'b1;
        if (w_hs) sent_cnt <= sent_cnt + 1'b1;
      end
      if (process_en) tags <= {tags[PIPE_LAT-2:0], state == STREAM};
    end
  end

`ifdef IS_DRIVER_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      bubble_cycles <= '0;
    end else if (start_ok) begin
      stall_cycles <= '0;
      bubble_cycles <= '0;
    end else begin
      if (busy & stall & ~&stall_cycles) stall_cycles <= stall_cycles + 1'b1;
      if (state == STREAM & ~w_valid & ~stall & ~&bubble_cycles) bubble_cycles <= bubble_cycles + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_systolic_array_is_driver.sv
// tb_systolic_array_is_driver: random-stimulus bench with a stand-in array and a golden matmul scoreboard.
module tb_systolic_array_is_driver;
  localparam int IW = 8, WW = 8, PW = 16, H = 4, W = 4, PL = H + W, CW = 16;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, w_valid = 0, out_ready = 0;
  logic [CW-1:0] num_vecs = '0;
  logic [H*IW-1:0] in_data = '0;
  logic [W*WW-1:0] w_data = '0;
  logic in_ready, w_ready, process_en, input_en, out_valid, busy, done;
  logic [H*IW-1:0] input_in;
  logic [W*WW-1:0] weight_in;
  logic [W*PW-1:0] psum_out, out_data;
`ifdef IS_DRIVER_PERF_CNT_EN
  logic [31:0] stall_cycles, bubble_cycles;
`endif
  int n_checks = 0, n_errors = 0;
  logic [H*IW-1:0] in_vecs [W];
  logic [W*WW-1:0] w_vecs [$];
  logic [W-1:0][H*IW-1:0] cols;
  logic [W*PW-1:0] dl [PL];

  systolic_array_is_driver #(
    .INPUT_WIDTH(IW), .WEIGHT_WIDTH(WW), .PSUM_WIDTH(PW),
    .ARRAY_HEIGHT(H), .ARRAY_WIDTH(W), .PIPE_LAT(PL), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vecs(num_vecs),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .process_en(process_en), .input_en(input_en), .input_in(input_in), .weight_in(weight_in),
    .psum_out(psum_out), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
`ifdef IS_DRIVER_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W*PW-1:0] array_mac(input logic [W-1:0][H*IW-1:0] cl, input logic [W*WW-1:0] wv);
    logic [W*PW-1:0] res;
    int acc;
    res = '0;
    for (int c = 0; c < W; c++) begin
      acc = 0;
      for (int r = 0; r < H; r++) acc += int'(cl[c][r*IW +: IW]) * int'(wv[r*WW +: WW]);
      res[c*PW +: PW] = acc[PW-1:0];
    end
    return res;
  endfunction

  // Stand-in array: stationary columns shift on input_en, psums delayed PL process_en cycles
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cols <= '0;
      for (int i = 0; i < PL; i++) dl[i] <= '0;
    end else if (process_en) begin
      if (input_en) cols <= {cols[W-2:0], input_in};
      dl[0] <= array_mac(cols, weight_in);
      for (int i = 1; i < PL; i++) dl[i] <= dl[i-1];
    end
  end
  assign psum_out = dl[PL-1];

  // Golden: column c holds the (W-1-c)-th loaded vector; result j = column dot weight j
  function automatic logic [W*PW-1:0] golden(input int j);
    logic [W*PW-1:0] g;
    logic [H*IW-1:0] iv;
    logic [W*WW-1:0] wv;
    int acc;
    wv = w_vecs[j];
    for (int c = 0; c < W; c++) begin
      iv = in_vecs[W-1-c];
      acc = 0;
      for (int r = 0; r < H; r++) acc = acc + iv[r*IW +: IW] * wv[r*WW +: WW];
      g[c*PW +: PW] = acc[PW-1:0];
    end
    return g;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, {busy, in_ready, w_ready, process_en, input_en, out_valid, done}, 0);
    check({tag, "_input_in"}, input_in, 0);
    check({tag, "_weight_in"}, weight_in, 0);
    check({tag, "_out_data"}, out_data, 0);
`ifdef IS_DRIVER_PERF_CNT_EN
    check({tag, "_perf"}, {stall_cycles, bubble_cycles}, 0);
`endif
  endtask

  task automatic run_job(input int n, input int wmode, input int rmode, input int imode,
                         input int abort_at, input bit chk_lat, input int exp_stall, input int exp_bubble);
    int li, wi, oi, dones, first, held, act;
    logic stl, prev_stall;
    logic [W*PW-1:0] prev_data;
    for (int k = 0; k < W; k++) in_vecs[k] = (H*IW)'($urandom);
    w_vecs.delete();
    for (int k = 0; k < n; k++) w_vecs.push_back((W*WW)'($urandom));
    li = 0; wi = 0; oi = 0; dones = 0; first = -1; held = 0; act = 0;
    prev_stall = 0; prev_data = '0;
    @(negedge clk);
    start = 1; num_vecs = CW'(n); in_valid = 0; w_valid = 0; out_ready = 1;
    @(negedge clk);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      start = 0;
      if (rmode == 1 && $urandom_range(0, 9) == 0) begin
        start = 1;
        num_vecs = CW'($urandom);
      end
      in_valid = imode == 0 ? 1'b1 : $urandom_range(0, 3) != 0;
      in_data = in_vecs[li < W ? li : 0];
      w_valid = wi < n && (wmode == 0 ? 1'b1 : wmode == 1 ? cyc % 2 == 0 : $urandom_range(0, 2) != 0);
      w_data = wi < n ? w_vecs[wi] : (W*WW)'($urandom);
      out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? $urandom_range(0, 2) != 0 : !(oi == 1 && held < 5);
      if (rmode == 2 && oi == 1 && held < 5) held++;
      #1;
      stl = out_valid & ~out_ready;
      if (in_ready & w_ready) check("ready_excl", {in_ready, w_ready}, 0);
      if (stl) check("stall_pe", process_en, 0);
      if (stl & prev_stall) check("hold_data", out_data, prev_data);
      if (in_valid & in_ready) begin
        check("in_pass", {input_en, process_en, input_in}, {2'b11, in_data});
        li++;
      end
      if (w_valid & w_ready) begin
        check("w_pass", {process_en, weight_in}, {1'b1, w_data});
        wi++;
      end
      if (out_valid & out_ready) begin
        if (oi < n) check("result", out_data, golden(oi));
        else check("extra_beat", oi + 1, n);
        if (first < 0) first = cyc;
        oi++;
      end
      if (n == 0 && (in_ready | w_ready | process_en)) act++;
      prev_stall = stl;
      prev_data = out_data;
      if (abort_at > 0 && wi == abort_at) break;
      if (done) begin
        start = 0;
        dones++;
        check("done_idle", busy, 0);
        check("done_results", oi, n);
        if (n == 0) check("done_lat", cyc, 0);
        break;
      end
    end
    start = 0;
    if (abort_at > 0) begin
      @(posedge clk);
      #2 rst_n = 0;
      #1 check_quiet("abort");
      @(negedge clk);
      rst_n = 1;
      in_valid = 0; w_valid = 0; out_ready = 1;
      return;
    end
    in_valid = 0; w_valid = 0; out_ready = 1;
    check("done_seen", dones, 1);
    check("loads", li, n == 0 ? 0 : W);
    check("weights", wi, n);
    if (chk_lat) check("latency", first, W + PL);
    if (n == 0) check("idle_act", act, 0);
    @(negedge clk);
    #1;
    check("done_pulse", done, 0);
    check("busy_after", busy, 0);
`ifdef IS_DRIVER_PERF_CNT_EN
    if (exp_stall >= 0) check("stall_cycles", stall_cycles, exp_stall);
    if (exp_bubble >= 0) check("bubble_cycles", bubble_cycles, exp_bubble);
`endif
  endtask

  initial begin
    #12 check_quiet("reset");
    @(negedge clk);
    rst_n = 1;
    run_job(3, 0, 0, 0, 0, 1, 0, 0);
    run_job(3, 0, 2, 0, 0, 1, 5, 0);
    run_job(6, 1, 0, 0, 0, 0, 0, 5);
    run_job(0, 0, 0, 0, 0, 0, 0, 0);
    run_job(5, 0, 0, 0, 2, 0, -1, -1);
    run_job(4, 0, 0, 0, 0, 1, 0, 0);
    for (int j = 0; j < 8; j++) run_job($urandom_range(1, 12), 2, 1, 1, 0, 0, -1, -1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
